// File: rtl/tinyriscv_pkg.sv
// rtl/tinyriscv_pkg.sv - core-wide bus widths and instruction prefetch queue types
package tinyriscv_pkg;

  localparam int MemAddrBus    = 32;
  localparam int InstBus       = 32;
  localparam int PrefetchDepth = 4;

  typedef struct packed {
    logic [MemAddrBus-1:0] addr;
    logic [InstBus-1:0]    inst;
  } pf_entry_t;

endpackage

// File: rtl/inst_prefetch_buf_fifo.sv
// rtl/inst_prefetch_buf_fifo.sv - register-array ring buffer of fetched instructions
// Occupancy is tracked by the owner; this block only moves the pointers.
module pf_fifo
  import tinyriscv_pkg::*;
#(
  parameter int DEPTH = PrefetchDepth
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  pf_entry_t push_data,
  input  logic      pop,
  input  logic      flush,
  output pf_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  pf_entry_t        mem [DEPTH];

  // Explicit compare keeps non-power-of-2 depths wrapping correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch_buf.sv
// rtl/inst_prefetch_buf.sv - sequential instruction prefetch queue with flush-aware response dropping
module inst_prefetch_buf
  import tinyriscv_pkg::*;
#(
  parameter int                DEPTH    = PrefetchDepth,
  parameter int                ADDR_W   = MemAddrBus,
  parameter int                INST_W   = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              fetch_req_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  input  logic              fetch_gnt_i,
  input  logic              fetch_rvalid_i,
  input  logic [INST_W-1:0] fetch_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  input  logic              halt_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  outst_q;
  logic [CNT_W-1:0]  discard_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] resp_pc_q;
  logic [CNT_W:0]    occupancy;
  logic [ADDR_W-1:0] flush_target;
  logic              gnt_fire;
  logic              push;
  logic              pop;
  pf_entry_t         push_entry;
  pf_entry_t         head_entry;

  // Queued plus in-flight fetches never exceed DEPTH, so a push always finds room.
  assign occupancy    = {1'b0, count_q} + {1'b0, outst_q};
  assign fetch_req_o  = rst_ni && !halt_i && !flush_i && (occupancy < (CNT_W + 1)'(DEPTH));
  assign fetch_addr_o = fetch_pc_q;
  assign gnt_fire     = fetch_req_o && fetch_gnt_i;
  assign flush_target = flush_addr_i & ~ADDR_W'(3);

  assign push         = fetch_rvalid_i && (discard_q == '0) && !flush_i;
  assign inst_valid_o = (count_q != '0) && !flush_i;
  assign pop          = inst_valid_o && inst_ready_i;

  assign push_entry.addr = resp_pc_q;
  assign push_entry.inst = fetch_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
    end else begin
      outst_q <= outst_q + CNT_W'(gnt_fire) - CNT_W'(fetch_rvalid_i);
      if (flush_i) begin
        // Everything still in flight after this cycle's response belongs to the old path.
        count_q    <= '0;
        fetch_pc_q <= flush_target;
        resp_pc_q  <= flush_target;
        discard_q  <= outst_q - CNT_W'(fetch_rvalid_i);
      end else begin
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        if (gnt_fire) fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
        if (push)     resp_pc_q  <= resp_pc_q + ADDR_W'(4);
        if (fetch_rvalid_i && (discard_q != '0)) discard_q <= discard_q - 1'b1;
      end
    end
  end

  pf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (flush_i),
    .head     (head_entry)
  );

  assign inst_o      = inst_valid_o ? head_entry.inst : '0;
  assign inst_addr_o = inst_valid_o ? head_entry.addr : '0;

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// tb/tb_inst_prefetch_buf.sv - directed and randomized checks of inst_prefetch_buf against a queue model
module tb_inst_prefetch_buf;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [2];
  logic        req        [2];
  logic [31:0] faddr      [2];
  logic        gnt        [2];
  logic        rvalid     [2];
  logic [31:0] rdata      [2];
  logic        ivalid     [2];
  logic [31:0] inst       [2];
  logic [31:0] iaddr      [2];
  logic        ready      [2];
  logic        flush      [2];
  logic [31:0] flush_addr [2];
  logic        halt       [2];

  inst_prefetch_buf #(.DEPTH(4)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n[0]), .fetch_req_o(req[0]), .fetch_addr_o(faddr[0]),
    .fetch_gnt_i(gnt[0]), .fetch_rvalid_i(rvalid[0]), .fetch_rdata_i(rdata[0]),
    .inst_valid_o(ivalid[0]), .inst_o(inst[0]), .inst_addr_o(iaddr[0]),
    .inst_ready_i(ready[0]), .flush_i(flush[0]), .flush_addr_i(flush_addr[0]), .halt_i(halt[0])
  );

  inst_prefetch_buf #(.DEPTH(3), .RESET_PC(32'hFFFF_FFF8)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n[1]), .fetch_req_o(req[1]), .fetch_addr_o(faddr[1]),
    .fetch_gnt_i(gnt[1]), .fetch_rvalid_i(rvalid[1]), .fetch_rdata_i(rdata[1]),
    .inst_valid_o(ivalid[1]), .inst_o(inst[1]), .inst_addr_o(iaddr[1]),
    .inst_ready_i(ready[1]), .flush_i(flush[1]), .flush_addr_i(flush_addr[1]), .halt_i(halt[1])
  );

  // Model: every outstanding fetch remembers its address and whether a flush made it stale.
  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

  pend_t       pend [$];
  ent_t        ent [$];
  logic [31:0] bus_q [$];
  logic [31:0] m_pc;
  int          depth;
  int          k;
  int          tests = 0;
  int          fails = 0;
  int          grants = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic [31:0] pc);
    pend.delete();
    ent.delete();
    bus_q.delete();
    m_pc = pc;
  endtask

  task automatic step(input bit g, input bit rv, input bit rdy, input bit fl,
                      input logic [31:0] fa, input bit hl);
    bit          e_req;
    bit          e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    pend_t       p;
    @(negedge clk);
    gnt[k]        = g;
    rvalid[k]     = rv && (bus_q.size() != 0);
    rdata[k]      = rvalid[k] ? memf(bus_q[0]) : 32'hDEAD_BEEF;
    ready[k]      = rdy;
    flush[k]      = fl;
    flush_addr[k] = fa;
    halt[k]       = hl;
    #1;
    e_req   = !hl && !fl && (ent.size() + pend.size() < depth);
    e_valid = (ent.size() != 0) && !fl;
    e_inst  = 32'h0;
    e_addr  = 32'h0;
    if (e_valid) begin
      e_inst = ent[0].data;
      e_addr = ent[0].addr;
    end
    chk("fetch_req", {31'h0, req[k]}, {31'h0, e_req});
    chk("fetch_addr", faddr[k], m_pc);
    chk("inst_valid", {31'h0, ivalid[k]}, {31'h0, e_valid});
    chk("inst", inst[k], e_inst);
    chk("inst_addr", iaddr[k], e_addr);
    if (rvalid[k]) void'(bus_q.pop_front());
    if (req[k] && g) begin
      bus_q.push_back(faddr[k]);
      grants++;
    end
    if (fl) begin
      if (rvalid[k] && pend.size() != 0) void'(pend.pop_front());
      ent.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_pc = fa & ~32'd3;
    end else begin
      if (e_valid && rdy) void'(ent.pop_front());
      if (rvalid[k] && pend.size() != 0) begin
        p = pend.pop_front();
        if (!p.stale) ent.push_back('{p.addr, memf(p.addr)});
      end
      if (e_req && g) begin
        pend.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    logic [31:0] first_addr;
    logic [31:0] first_data;
    logic [31:0] resume_pc;
    logic [31:0] wrap_addr [3];
    int          first_idx;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; gnt[i] = 1'b0; rvalid[i] = 1'b0; rdata[i] = '0; ready[i] = 1'b0;
      flush[i] = 1'b0; flush_addr[i] = '0; halt[i] = 1'b0;
    end
    k = 0;
    depth = 4;
    model_reset(32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'h0, req[0]}, 32'h0);
    chk("rst_fetch_addr", faddr[0], 32'h0);
    chk("rst_valid", {31'h0, ivalid[0]}, 32'h0);
    chk("rst_inst", inst[0], 32'h0);
    chk("rst_inst_addr", iaddr[0], 32'h0);
    @(negedge clk);
    rst_n[0] = 1'b1;

    // streaming with a 1-cycle bus and an always-ready consumer
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 32'h0, 0);

    // stalled consumer fills exactly DEPTH entries
    step(0, 1, 1, 1, 32'h0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 32'h0, 0);
    grants = 0;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 32'h0, 0);
    chk("stall_grants", grants, 32'd4);
    chk("stall_valid", {31'h0, ivalid[0]}, 32'h1);
    step(1, 1, 1, 0, 32'h0, 0);
    grants = 0;
    step(1, 1, 0, 0, 32'h0, 0);
    chk("refill_addr", faddr[0], 32'h10);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h0, 0);
    chk("refill_grants", grants, 32'd1);

    // flush with three fetches in flight
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 32'h0, 0);
    step(0, 0, 1, 1, 32'h203, 0);
    first_idx = -1;
    first_addr = '0;
    first_data = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 1, 0, 32'h0, 0);
      if (ivalid[0] && first_idx < 0) begin
        first_idx = i;
        first_addr = iaddr[0];
        first_data = inst[0];
      end
    end
    chk("flush_first_addr", first_addr, 32'h200);
    chk("flush_first_data", first_data, memf(32'h200));
    chk("flush_latency", {31'h0, first_idx >= 2}, 32'h1);

    // flush coincident with a response and a pop
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 32'h0, 0);
    step(1, 1, 0, 0, 32'h0, 0);
    step(1, 1, 1, 1, 32'h400, 0);
    step(0, 0, 1, 0, 32'h0, 0);
    chk("flush_pop_empty", {31'h0, ivalid[0]}, 32'h0);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 32'h0, 0);

    // halt with two fetches in flight
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 32'h0, 0);
    resume_pc = faddr[0];
    for (int i = 0; i < 2; i++) step(1, 0, 1, 0, 32'h0, 0);
    grants = 0;
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 32'h0, 1);
    chk("halt_grants", grants, 32'd0);
    step(1, 1, 1, 0, 32'h0, 0);
    chk("halt_resume_addr", faddr[0], resume_pc + 32'd8);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 32'h0, 0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h0, 0);
    @(negedge clk);
    gnt[0] = 1'b0; rvalid[0] = 1'b0;
    rst_n[0] = 1'b0;
    #1;
    chk("midrst_req", {31'h0, req[0]}, 32'h0);
    chk("midrst_valid", {31'h0, ivalid[0]}, 32'h0);
    chk("midrst_fetch_addr", faddr[0], 32'h0);
    chk("midrst_inst", inst[0], 32'h0);

    // DEPTH=3 instance: address wrap and randomized stalls
    k = 1;
    depth = 3;
    model_reset(32'hFFFF_FFF8);
    #1;
    chk("d3_rst_fetch_addr", faddr[1], 32'hFFFF_FFF8);
    @(negedge clk);
    rst_n[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 32'h0, 0);
      wrap_addr[i] = faddr[1];
    end
    chk("wrap_a0", wrap_addr[0], 32'hFFFF_FFF8);
    chk("wrap_a1", wrap_addr[1], 32'hFFFF_FFFC);
    chk("wrap_a2", wrap_addr[2], 32'h0);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("d3_full_req", {31'h0, req[1]}, 32'h0);
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0,
           ($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFF_FFF1,
           $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
